boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 92 +++++++++
 tb/tb_boot_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - copies an 8-word boot ROM image into RAM, then releases the CPU from reset.
module boot_loader #(
  parameter int          RAM_AW   = 8,
  parameter int unsigned RAM_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rom_cs,
  output logic              rom_we,
  output logic [2:0]        rom_addr,
  input  logic [15:0]       rom_dout,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic              busy,
  output logic              done,
  output logic              cpu_rst,
  output logic [15:0]       csum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [2:0]        r_idx;
  logic [15:0]       r_data;
  logic [15:0]       r_csum;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [RAM_AW-1:0] w_ram_base;
  logic [RAM_AW-1:0] w_ram_addr_next;

  assign w_ram_base      = RAM_BASE[RAM_AW-1:0];
  assign w_ram_addr_next = w_ram_base + RAM_AW'(r_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_data     <= 16'h0000;
      r_csum     <= 16'h0000;
      r_ram_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_READ;
          r_idx   <= 3'd0;
          r_csum  <= 16'h0000;
        end
        S_READ: begin
          // ram_addr is registered here so it holds its last value once the copy ends
          r_state    <= S_WRITE;
          r_data     <= rom_dout;
          r_csum     <= r_csum + rom_dout;
          r_ram_addr <= w_ram_addr_next;
        end
        S_WRITE: begin
          if (r_idx == 3'd7) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_READ;
            r_idx   <= r_idx + 3'd1;
          end
        end
        S_DONE: begin
          if (start) begin
            r_state <= S_READ;
            r_idx   <= 3'd0;
            r_csum  <= 16'h0000;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_cs   = (r_state == S_READ);
  assign rom_we   = 1'b0;
  assign rom_addr = r_idx;
  assign ram_cs   = (r_state == S_WRITE);
  assign ram_we   = (r_state == S_WRITE);
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_data;
  assign busy     = (r_state == S_READ) || (r_state == S_WRITE);
  assign done     = (r_state == S_DONE);
  assign cpu_rst  = (r_state != S_DONE);
  assign csum     = r_csum;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - scoreboard bench for boot_loader with RAM_BASE 0 and FC.
module tb_boot_loader;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;

  logic        rom_cs0, rom_we0, ram_cs0, ram_we0, busy0, done0, cpu_rst0;
  logic [2:0]  rom_addr0;
  logic [15:0] rom_dout0, ram_din0, csum0;
  logic [7:0]  ram_addr0;

  logic        rom_cs1, rom_we1, ram_cs1, ram_we1, busy1, done1, cpu_rst1;
  logic [2:0]  rom_addr1;
  logic [15:0] rom_dout1, ram_din1, csum1;
  logic [7:0]  ram_addr1;

  logic [15:0] rom  [8];
  logic [15:0] ram0 [256];
  logic [15:0] ram1 [256];

  int n_checks = 0;
  int n_errors = 0;

  int  rdq[$];
  wr_t wq0[$];
  wr_t wq1[$];

  always #5 clk = ~clk;

  assign rom_dout0 = rom[rom_addr0];
  assign rom_dout1 = rom[rom_addr1];

  boot_loader #(.RAM_AW(8), .RAM_BASE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start),
    .rom_cs(rom_cs0), .rom_we(rom_we0), .rom_addr(rom_addr0), .rom_dout(rom_dout0),
    .ram_cs(ram_cs0), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_din(ram_din0),
    .busy(busy0), .done(done0), .cpu_rst(cpu_rst0), .csum(csum0)
  );

  boot_loader #(.RAM_AW(8), .RAM_BASE(32'hFC)) u_dut1 (
    .clk(clk), .rst(rst), .start(start),
    .rom_cs(rom_cs1), .rom_we(rom_we1), .rom_addr(rom_addr1), .rom_dout(rom_dout1),
    .ram_cs(ram_cs1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1),
    .busy(busy1), .done(done1), .cpu_rst(cpu_rst1), .csum(csum1)
  );

  always @(posedge clk) begin
    if (ram_cs0 && ram_we0) ram0[ram_addr0] <= ram_din0;
    if (ram_cs1 && ram_we1) ram1[ram_addr1] <= ram_din1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a ROM read or RAM write.
  always @(negedge clk) begin
    wr_t e;
    int  r;
    chk("cs_exclusive0", {31'd0, rom_cs0 && ram_cs0}, 32'd0);
    chk("cs_exclusive1", {31'd0, rom_cs1 && ram_cs1}, 32'd0);
    if (rom_cs0) begin
      if (rdq.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
      else begin
        r = rdq.pop_front();
        chk("rom_addr", {29'd0, rom_addr0}, r);
        chk("rom_we", {31'd0, rom_we0}, 32'd0);
        chk("rom_addr_dut1", {29'd0, rom_addr1}, r);
      end
    end
    if (ram_cs0 && ram_we0) begin
      if (wq0.size() == 0) chk("unexpected_write0", 32'd1, 32'd0);
      else begin
        e = wq0.pop_front();
        chk("wr_addr0", {24'd0, ram_addr0}, {24'd0, e.a});
        chk("wr_data0", {16'd0, ram_din0}, {16'd0, e.d});
      end
    end
    if (ram_cs1 && ram_we1) begin
      if (wq1.size() == 0) chk("unexpected_write1", 32'd1, 32'd0);
      else begin
        e = wq1.pop_front();
        chk("wr_addr1", {24'd0, ram_addr1}, {24'd0, e.a});
        chk("wr_data1", {16'd0, ram_din1}, {16'd0, e.d});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_copy(input int n_rd, input int n_wr);
    for (int i = 0; i < n_rd; i++) rdq.push_back(i);
    for (int i = 0; i < n_wr; i++) begin
      wq0.push_back({8'(i), rom[i]});
      wq1.push_back({8'(8'hFC + 8'(i)), rom[i]});
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rom_cs"},   {31'd0, rom_cs0 | rom_cs1}, 32'd0);
    chk({tag, "_rom_we"},   {31'd0, rom_we0 | rom_we1}, 32'd0);
    chk({tag, "_rom_addr"}, {26'd0, rom_addr0, rom_addr1}, 32'd0);
    chk({tag, "_ram_cs"},   {30'd0, ram_cs0, ram_cs1}, 32'd0);
    chk({tag, "_ram_we"},   {30'd0, ram_we0, ram_we1}, 32'd0);
    chk({tag, "_ram_addr"}, {16'd0, ram_addr0, ram_addr1}, 32'd0);
    chk({tag, "_ram_din"},  {ram_din0, ram_din1}, 32'd0);
    chk({tag, "_busy"},     {30'd0, busy0, busy1}, 32'd0);
    chk({tag, "_done"},     {30'd0, done0, done1}, 32'd0);
    chk({tag, "_cpu_rst"},  {30'd0, cpu_rst0, cpu_rst1}, 32'd3);
    chk({tag, "_csum"},     {csum0, csum1}, 32'd0);
  endtask

  initial begin
    logic [15:0] img [8];
    img = '{16'hF200, 16'h4000, 16'hF800, 16'hF400, 16'hB008, 16'h4000, 16'h4000, 16'h0008};
    for (int i = 0; i < 8; i++) rom[i] = img[i];
    for (int i = 0; i < 256; i++) begin
      ram0[i] = 16'hDEAD;
      ram1[i] = 16'hDEAD;
    end
    rst   = 1'b1;
    start = 1'b0;
    cyc(2);
    chk_reset("reset");

    // Boot after reset with start held through the copy: it must be ignored.
    push_copy(8, 8);
    start = 1'b1;
    rst   = 1'b0;
    cyc(16);
    chk("boot_e16_done", {30'd0, done0, done1}, 32'd0);
    chk("boot_e16_busy", {30'd0, busy0, busy1}, 32'd3);
    start = 1'b0;
    cyc(1);
    chk("boot_e17_done", {30'd0, done0, done1}, 32'd3);
    chk("boot_e17_cpu_rst", {30'd0, cpu_rst0, cpu_rst1}, 32'd0);
    chk("boot_e17_busy", {30'd0, busy0, busy1}, 32'd0);
    chk("boot_csum", {csum0, csum1}, {16'h4E10, 16'h4E10});
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ram0[%0d]", i), {16'd0, ram0[i]}, {16'd0, img[i]});
      chk($sformatf("ram1[%0h]", 8'(8'hFC + 8'(i))), {16'd0, ram1[8'(8'hFC + 8'(i))]}, {16'd0, img[i]});
    end
    chk("hold_addr_dut1", {24'd0, ram_addr1}, 32'h03);

    cyc(3);
    chk("done_hold", {30'd0, done0, done1}, 32'd3);

    // Reload with ROM word 7 changed; start pulsed for one cycle.
    rom[7] = 16'h0000;
    push_copy(8, 8);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("reload_done_fall", {30'd0, done0, done1}, 32'd0);
    cyc(15);
    chk("reload_e16_done", {30'd0, done0, done1}, 32'd0);
    cyc(1);
    chk("reload_e17_done", {30'd0, done0, done1}, 32'd3);
    chk("reload_csum", {csum0, csum1}, {16'h4E08, 16'h4E08});
    chk("reload_ram0[7]", {16'd0, ram0[7]}, 32'd0);
    chk("reload_ram1[03]", {16'd0, ram1[3]}, 32'd0);

    // Reset asserted between clock edges while idx 4 is being written.
    rom[7] = 16'h0008;
    push_copy(5, 5);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(9);
    chk("mid_write_we", {30'd0, ram_we0, ram_we1}, 32'd3);
    chk("mid_write_addr", {24'd0, ram_addr0}, 32'd4);
    #2 rst = 1'b1;
    #1 chk_reset("async");
    cyc(2);
    chk("partial_ram0[4]", {16'd0, ram0[4]}, 32'hB008);
    push_copy(8, 8);
    rst = 1'b0;
    cyc(16);
    chk("rerun_e16_done", {30'd0, done0, done1}, 32'd0);
    cyc(1);
    chk("rerun_e17_done", {30'd0, done0, done1}, 32'd3);
    chk("rerun_csum", {csum0, csum1}, {16'h4E10, 16'h4E10});
    chk("rerun_ram0[7]", {16'd0, ram0[7]}, 32'h0008);

    cyc(2);
    chk("rdq_empty", rdq.size(), 32'd0);
    chk("wq0_empty", wq0.size(), 32'd0);
    chk("wq1_empty", wq1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
